// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU micro-sequencer.
//   - opcode values (OP_LDA..OP_ILL)
//   - state encoding (S_*)
//   - ACC shift-mode constants (SH_*)
//   - ctl_t: the full registered control/status word driven by the sequencer
package alu_seq_pkg;

  localparam logic [2:0] OP_LDA = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;
  localparam logic [2:0] OP_DIV = 3'b101;
  localparam logic [2:0] OP_OUT = 3'b110;
  localparam logic [2:0] OP_ILL = 3'b111;

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_LOAD_H = 4'd1;
  localparam logic [3:0] S_XFER   = 4'd2;
  localparam logic [3:0] S_CLRH   = 4'd3;
  localparam logic [3:0] S_M_ADD  = 4'd4;
  localparam logic [3:0] S_M_SHR  = 4'd5;
  localparam logic [3:0] S_D_SHL  = 4'd6;
  localparam logic [3:0] S_D_SUB  = 4'd7;
  localparam logic [3:0] S_EXEC   = 4'd8;
  localparam logic [3:0] S_DONE   = 4'd9;

  localparam logic [1:0] SH_HOLD = 2'b00;
  localparam logic [1:0] SH_SHR  = 2'b01;
  localparam logic [1:0] SH_SHL  = 2'b10;
  localparam logic [1:0] SH_LOAD = 2'b11;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       err;
    logic       ah_inen;
    logic       ah_reset;
    logic [1:0] hs;
    logic [1:0] ls;
    logic       s_add;
    logic       s_sub;
    logic       s_and;
    logic       s_mul;
    logic       s_div;
    logic       acc_oen;
  } ctl_t;

endpackage

// File: rtl/alu_op_sequencer_iter_counter.sv
// Iteration counter for the multiply/divide loops.
//   clk  : clock
//   clr  : async active-high reset, count -> 0
//   init : synchronous clear (asserted while in CLRH)
//   inc  : advance by one (on leaving a loop's second state); saturates
//   last : count == WIDTH-1
module iter_counter #(
  parameter int WIDTH  = 4,
  parameter int ITER_W = 3
) (
  input  logic clk,
  input  logic clr,
  input  logic init,
  input  logic inc,
  output logic last
);

  logic [ITER_W-1:0] cnt;

  always_ff @(posedge clk or posedge clr) begin
    if (clr)                   cnt <= '0;
    else if (init)             cnt <= '0;
    else if (inc && cnt != '1) cnt <= cnt + 1'b1;  // hold at max, never wrap
  end

  assign last = (cnt == ITER_W'(WIDTH - 1));

endmodule

// File: rtl/alu_op_sequencer.sv
// Micro-sequencer driving the aluNacc control lines, one opcode per start.
// Ports:
//   clk, clr          : clock, async active-high reset
//   start, opcode     : request and opcode, sampled only in IDLE
//   busy, done, err   : status to the instruction controller
//   ah_inen, ah_reset : ACC-high load-from-bus / clear
//   hs, ls            : ACC-high / ACC-low mode (hold/shr/shl/load)
//   s_add..s_div      : ALU function selects (one-hot or none)
//   acc_oen           : accumulator output enable
// All outputs are registered: the output word is decoded from the next state
// so it changes on the same edge as the state register.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int ITER_W = 3
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       start,
  input  logic [2:0] opcode,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       ah_inen,
  output logic       ah_reset,
  output logic [1:0] hs,
  output logic [1:0] ls,
  output logic       s_add,
  output logic       s_sub,
  output logic       s_and,
  output logic       s_mul,
  output logic       s_div,
  output logic       acc_oen
);

  logic [3:0] state, state_nxt;
  logic [2:0] op_q, op_nxt;
  logic       accept, last, cnt_init, cnt_inc;
  ctl_t       ctl_q, ctl_nxt;

  assign accept   = (state == S_IDLE) && start;
  assign op_nxt   = accept ? opcode : op_q;
  assign cnt_init = (state == S_CLRH);
  assign cnt_inc  = (state == S_M_SHR) || (state == S_D_SUB);

  iter_counter #(.WIDTH(WIDTH), .ITER_W(ITER_W)) u_iter (
    .clk  (clk),
    .clr  (clr),
    .init (cnt_init),
    .inc  (cnt_inc),
    .last (last)
  );

  // state / opcode / output registers
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= S_IDLE;
      op_q  <= OP_LDA;
      ctl_q <= '0;
    end else begin
      state <= state_nxt;
      op_q  <= op_nxt;
      ctl_q <= ctl_nxt;
    end
  end

  // next state
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) begin
        case (opcode)
          OP_LDA, OP_MUL, OP_DIV:         state_nxt = S_LOAD_H;
          OP_ADD, OP_SUB, OP_AND, OP_OUT: state_nxt = S_EXEC;
          default:                        state_nxt = S_DONE;
        endcase
      end
      S_LOAD_H: state_nxt = (op_q == OP_LDA) ? S_DONE : S_XFER;
      S_XFER:   state_nxt = S_CLRH;
      S_CLRH:   state_nxt = (op_q == OP_MUL) ? S_M_ADD : S_D_SHL;
      S_M_ADD:  state_nxt = S_M_SHR;
      S_M_SHR:  state_nxt = last ? S_DONE : S_M_ADD;
      S_D_SHL:  state_nxt = S_D_SUB;
      S_D_SUB:  state_nxt = last ? S_DONE : S_D_SHL;
      S_EXEC:   state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // output decode of the state being entered
  always_comb begin
    ctl_nxt      = '0;
    ctl_nxt.busy = (state_nxt != S_IDLE);
    case (state_nxt)
      S_LOAD_H: begin ctl_nxt.ah_inen = 1'b1; ctl_nxt.hs = SH_LOAD; end
      S_XFER:   ctl_nxt.ls = SH_LOAD;
      S_CLRH:   ctl_nxt.ah_reset = 1'b1;
      S_M_ADD:  begin ctl_nxt.hs = SH_LOAD; ctl_nxt.s_mul = 1'b1; end
      S_M_SHR:  begin ctl_nxt.hs = SH_SHR;  ctl_nxt.ls = SH_SHR; end
      S_D_SHL:  begin ctl_nxt.hs = SH_SHL;  ctl_nxt.ls = SH_SHL; end
      S_D_SUB:  begin ctl_nxt.hs = SH_LOAD; ctl_nxt.s_div = 1'b1; end
      S_EXEC: begin
        case (op_nxt)
          OP_ADD:  begin ctl_nxt.hs = SH_LOAD; ctl_nxt.s_add = 1'b1; end
          OP_SUB:  begin ctl_nxt.hs = SH_LOAD; ctl_nxt.s_sub = 1'b1; end
          OP_AND:  begin ctl_nxt.hs = SH_LOAD; ctl_nxt.s_and = 1'b1; end
          OP_OUT:  ctl_nxt.acc_oen = 1'b1;
          default: ;
        endcase
      end
      S_DONE: begin
        ctl_nxt.done = 1'b1;
        ctl_nxt.err  = (op_nxt == OP_ILL);
      end
      default: ;
    endcase
  end

  assign busy     = ctl_q.busy;
  assign done     = ctl_q.done;
  assign err      = ctl_q.err;
  assign ah_inen  = ctl_q.ah_inen;
  assign ah_reset = ctl_q.ah_reset;
  assign hs       = ctl_q.hs;
  assign ls       = ctl_q.ls;
  assign s_add    = ctl_q.s_add;
  assign s_sub    = ctl_q.s_sub;
  assign s_and    = ctl_q.s_and;
  assign s_mul    = ctl_q.s_mul;
  assign s_div    = ctl_q.s_div;
  assign acc_oen  = ctl_q.acc_oen;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: directed scenarios then randomized ops with
// start/opcode noise while busy. Expected per-cycle control words come from a
// per-opcode trace table built from the operation's step list.
module tb_alu_op_sequencer;
  localparam int WIDTH = 4;

  logic       clk, clr, start;
  logic [2:0] opcode;
  logic       busy, done, err, ah_inen, ah_reset;
  logic [1:0] hs, ls;
  logic       s_add, s_sub, s_and, s_mul, s_div, acc_oen;

  int vectors = 0;
  int miscompares = 0;
  logic [14:0] exp_q[$];

  alu_op_sequencer #(.WIDTH(WIDTH), .ITER_W(3)) dut (
    .clk(clk), .clr(clr), .start(start), .opcode(opcode),
    .busy(busy), .done(done), .err(err), .ah_inen(ah_inen), .ah_reset(ah_reset),
    .hs(hs), .ls(ls), .s_add(s_add), .s_sub(s_sub), .s_and(s_and),
    .s_mul(s_mul), .s_div(s_div), .acc_oen(acc_oen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // word: {busy,done,err,ah_inen,ah_reset,hs,ls,add,sub,and,mul,div,oen}
  function automatic logic [14:0] mk(input bit b, input bit d, input bit e,
                                     input bit ai, input bit ar,
                                     input logic [1:0] h, input logic [1:0] l,
                                     input logic [4:0] sel, input bit oe);
    return {b, d, e, ai, ar, h, l, sel, oe};
  endfunction

  task automatic check(input string tag, input logic [14:0] expv);
    logic [14:0] obs;
    obs = {busy, done, err, ah_inen, ah_reset, hs, ls,
           s_add, s_sub, s_and, s_mul, s_div, acc_oen};
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  // cycle-by-cycle expected words from accept through DONE
  task automatic build(input logic [2:0] op);
    exp_q.delete();
    case (op)
      3'd0: exp_q.push_back(mk(1,0,0,1,0,2'b11,2'b00,5'b00000,0));
      3'd1: exp_q.push_back(mk(1,0,0,0,0,2'b11,2'b00,5'b10000,0));
      3'd2: exp_q.push_back(mk(1,0,0,0,0,2'b11,2'b00,5'b01000,0));
      3'd3: exp_q.push_back(mk(1,0,0,0,0,2'b11,2'b00,5'b00100,0));
      3'd6: exp_q.push_back(mk(1,0,0,0,0,2'b00,2'b00,5'b00000,1));
      3'd4, 3'd5: begin
        exp_q.push_back(mk(1,0,0,1,0,2'b11,2'b00,5'b00000,0));
        exp_q.push_back(mk(1,0,0,0,0,2'b00,2'b11,5'b00000,0));
        exp_q.push_back(mk(1,0,0,0,1,2'b00,2'b00,5'b00000,0));
        for (int k = 0; k < WIDTH; k++) begin
          if (op == 3'd4) begin
            exp_q.push_back(mk(1,0,0,0,0,2'b11,2'b00,5'b00010,0));
            exp_q.push_back(mk(1,0,0,0,0,2'b01,2'b01,5'b00000,0));
          end else begin
            exp_q.push_back(mk(1,0,0,0,0,2'b10,2'b10,5'b00000,0));
            exp_q.push_back(mk(1,0,0,0,0,2'b11,2'b00,5'b00001,0));
          end
        end
      end
      default: ;
    endcase
    exp_q.push_back(mk(1,1,(op == 3'd7),0,0,2'b00,2'b00,5'b00000,0));
  endtask

  // called at a negedge in IDLE; returns at the negedge of the trailing IDLE cycle
  task automatic run_op(input logic [2:0] op, input bit hold, input int noise,
                        input string tag);
    build(op);
    start  = 1'b1;
    opcode = op;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      if (!hold) start = 1'b0;
      check($sformatf("%s_c%0d", tag, i + 1), exp_q[i]);
      if (i + 1 == noise) begin
        start  = 1'b1;
        opcode = 3'($urandom);
      end
    end
    @(negedge clk);
    if (!hold) start = 1'b0;
    check({tag, "_idle"}, 15'd0);
  endtask

  initial begin
    clr = 1'b1; start = 1'b0; opcode = 3'd0;
    repeat (2) begin
      @(negedge clk);
      check("reset", 15'd0);
    end
    clr = 1'b0;
    @(negedge clk);
    check("idle_after_reset", 15'd0);

    // MUL with start/opcode noise on cycle 5
    run_op(3'd4, 1'b0, 5, "mul");
    run_op(3'd5, 1'b0, 0, "div");
    run_op(3'd0, 1'b0, 0, "lda");

    // start held: four single-step ops, 3 cycles each
    run_op(3'd1, 1'b1, 0, "add");
    run_op(3'd2, 1'b1, 0, "sub");
    run_op(3'd3, 1'b1, 0, "and");
    run_op(3'd6, 1'b1, 0, "out");
    start = 1'b0;

    run_op(3'd7, 1'b0, 0, "ill");

    // clr during M_SHR (cycle 5) of a MUL
    build(3'd4);
    start = 1'b1; opcode = 3'd4;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      start = 1'b0;
      check($sformatf("mulclr_c%0d", i + 1), exp_q[i]);
    end
    clr = 1'b1;
    #1 check("clr_immediate", 15'd0);
    repeat (10) begin
      @(negedge clk);
      check("clr_hold", 15'd0);
    end
    clr = 1'b0;
    @(negedge clk);
    check("clr_release", 15'd0);
    run_op(3'd4, 1'b0, 0, "mul_after_clr");

    // randomized ops with random hold and noise
    for (int n = 0; n < 150; n++) begin
      run_op(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
             int'($urandom_range(0, 14)), $sformatf("rnd%0d", n));
    end
    start = 1'b0;
    @(negedge clk);
    check("final_idle", 15'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
